// File: rtl/matrix_relu_pool_pkg.sv
// Shared types and constants for the ReLU / 2x2 max-pool engine.
// Memory request codes match the other accelerator engines.
package matrix_relu_pool_pkg;

  localparam int TYPE_BW = 32;
  localparam int KICP_SRAM_AWIDTH = 8;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  typedef struct packed {
    logic [1:0]         op;
    logic [TYPE_BW-1:0] addr;
    logic [TYPE_BW-1:0] data;
  } mem_req_t;

  function automatic logic [TYPE_BW-1:0] wrap_addr(
    input logic [TYPE_BW-1:0] a,
    input int                 aw
  );
    logic [TYPE_BW-1:0] m;
    m = (aw >= TYPE_BW) ? '1
      : ((TYPE_BW'(1) << aw) - TYPE_BW'(1));
    return a & m;
  endfunction

endpackage

// File: rtl/matrix_relu_pool_if.sv
// SRAM request port between an engine and the memory controller.
// The engine side is the master.
interface matrix_relu_pool_if;
  import matrix_relu_pool_pkg::*;

  logic [TYPE_BW-1:0] addr_o;
  logic [TYPE_BW-1:0] data_o;
  logic [TYPE_BW-1:0] data_i;
  logic [1:0]         mem_operation;
  logic               mem_opdone;

  modport master (
    output addr_o,
    output data_o,
    output mem_operation,
    input  data_i,
    input  mem_opdone
  );

  modport slave (
    input  addr_o,
    input  data_o,
    input  mem_operation,
    output data_i,
    output mem_opdone
  );

endinterface

// File: rtl/matrix_relu_pool_relu_max4.sv
// Registered signed running max with clear/load/fold controls.
// The output is clamped at zero (ReLU).
module relu_max4
  import matrix_relu_pool_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               fold,
  input  logic [TYPE_BW-1:0] din,
  output logic [TYPE_BW-1:0] dout
);

  logic signed [TYPE_BW-1:0] acc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      unique case (1'b1)
        clear: acc_q <= '0;
        load:  acc_q <= din;
        fold:  if ($signed(din) > acc_q) acc_q <= din;
        default: ;
      endcase
    end
  end

  assign dout = acc_q[TYPE_BW-1] ? '0 : acc_q;

endmodule

// File: rtl/matrix_relu_pool.sv
// Reads a matrix from SRAM, applies 2x2 max-pool + ReLU, writes it back.
// Header words go out last so a nonzero header marks complete data.
module matrix_relu_pool
  import matrix_relu_pool_pkg::*;
#(
  parameter int AWIDTH   = KICP_SRAM_AWIDTH,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 128
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               done,
  output logic               error,
  matrix_relu_pool_if.master mem
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_R,
    S_RD_C,
    S_CHECK,
    S_RD_WIN,
    S_WR_EL,
    S_WR_HR,
    S_WR_HC,
    S_DONE
  } state_t;

  localparam logic [TYPE_BW-1:0] IN_W  = TYPE_BW'(IN_BASE);
  localparam logic [TYPE_BW-1:0] OUT_W = TYPE_BW'(OUT_BASE);

  state_t             state_q;
  logic [TYPE_BW-1:0] r_q;
  logic [TYPE_BW-1:0] c_q;
  logic [15:0]        i_q;
  logic [15:0]        j_q;
  logic [1:0]         k_q;

  logic [15:0]        hr;
  logic [15:0]        hc;
  logic [TYPE_BW-1:0] row;
  logic [TYPE_BW-1:0] col;
  logic [TYPE_BW-1:0] rd_full;
  logic [TYPE_BW-1:0] wr_full;
  logic [TYPE_BW-1:0] pooled;
  logic               dim_bad;
  logic               pend;
  logic               is_req;
  logic               win_done;
  mem_req_t           req;

  assign hr   = r_q[16:1];
  assign hc   = c_q[16:1];
  assign pend = (mem.mem_operation != MEM_OP_NONE);

  assign dim_bad = (|r_q[31:16]) | (|c_q[31:16])
                 | (r_q[15:1] == '0) | (c_q[15:1] == '0);

  // k_q[1] selects the lower row, k_q[0] the right column
  always_comb begin
    row     = {15'd0, i_q, k_q[1]};
    col     = {15'd0, j_q, k_q[0]};
    rd_full = IN_W + 32'd2 + row * c_q + col;
    wr_full = OUT_W + 32'd2
            + {16'd0, i_q} * {16'd0, hc}
            + {16'd0, j_q};
  end

  always_comb begin
    req    = '0;
    is_req = 1'b1;
    unique case (state_q)
      S_RD_R: begin
        req.op   = MEM_OP_READ;
        req.addr = wrap_addr(IN_W, AWIDTH);
      end
      S_RD_C: begin
        req.op   = MEM_OP_READ;
        req.addr = wrap_addr(IN_W + 32'd1, AWIDTH);
      end
      S_RD_WIN: begin
        req.op   = MEM_OP_READ;
        req.addr = wrap_addr(rd_full, AWIDTH);
      end
      S_WR_EL: begin
        req.op   = MEM_OP_WRITE;
        req.addr = wrap_addr(wr_full, AWIDTH);
        req.data = pooled;
      end
      S_WR_HR: begin
        req.op   = MEM_OP_WRITE;
        req.addr = wrap_addr(OUT_W, AWIDTH);
        req.data = {16'd0, hr};
      end
      S_WR_HC: begin
        req.op   = MEM_OP_WRITE;
        req.addr = wrap_addr(OUT_W + 32'd1, AWIDTH);
        req.data = {16'd0, hc};
      end
      default: is_req = 1'b0;
    endcase
  end

  assign win_done = (state_q == S_RD_WIN) & pend
                  & mem.mem_opdone;

  relu_max4 u_max (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == S_IDLE),
    .load    (win_done & (k_q == 2'd0)),
    .fold    (win_done & (k_q != 2'd0)),
    .din     (mem.data_i),
    .dout    (pooled)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      r_q               <= '0;
      c_q               <= '0;
      i_q               <= '0;
      j_q               <= '0;
      k_q               <= '0;
      done              <= 1'b0;
      error             <= 1'b0;
      mem.mem_operation <= MEM_OP_NONE;
      mem.addr_o        <= '0;
      mem.data_o        <= '0;
    end else if (is_req) begin
      if (pend) begin
        if (mem.mem_opdone) begin
          mem.mem_operation <= MEM_OP_NONE;
          if (!enable) begin
            state_q <= S_IDLE;
          end else begin
            unique case (state_q)
              S_RD_R: begin
                r_q     <= mem.data_i;
                state_q <= S_RD_C;
              end
              S_RD_C: begin
                c_q     <= mem.data_i;
                state_q <= S_CHECK;
              end
              S_RD_WIN: begin
                k_q <= k_q + 2'd1;
                if (k_q == 2'd3) state_q <= S_WR_EL;
              end
              S_WR_EL: begin
                state_q <= S_RD_WIN;
                if (j_q == hc - 16'd1) begin
                  j_q <= '0;
                  if (i_q == hr - 16'd1) state_q <= S_WR_HR;
                  else i_q <= i_q + 16'd1;
                end else begin
                  j_q <= j_q + 16'd1;
                end
              end
              S_WR_HR: state_q <= S_WR_HC;
              S_WR_HC: begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      end else if (!enable) begin
        state_q <= S_IDLE;
      end else begin
        mem.mem_operation <= req.op;
        mem.addr_o        <= req.addr;
        mem.data_o        <= req.data;
      end
    end else begin
      unique case (state_q)
        S_IDLE: if (enable) state_q <= S_RD_R;
        S_CHECK: begin
          if (!enable) begin
            state_q <= S_IDLE;
          end else if (dim_bad) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            error   <= 1'b1;
          end else begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            error   <= 1'b0;
            state_q <= S_RD_WIN;
          end
        end
        S_DONE: if (!enable) begin
          state_q <= S_IDLE;
          done    <= 1'b0;
          error   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_relu_pool.sv
// Random-latency SRAM responder plus a window-level pooling model.
// Transaction logs are compared entry by entry against the model.
module tb_matrix_relu_pool;

  localparam int IN_B  = 0;
  localparam int OUT_B = 128;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic done;
  logic error;

  matrix_relu_pool_if bus ();

  matrix_relu_pool #(
    .AWIDTH   (8),
    .IN_BASE  (IN_B),
    .OUT_BASE (OUT_B)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .done    (done),
    .error   (error),
    .mem     (bus)
  );

  always #5 clk = ~clk;

  tx_t         log_q[$];
  tx_t         exp_q[$];
  logic [31:0] sram [0:255];
  logic [31:0] vals [0:125];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          force_lat = -1;

  bit          r_active;
  bit          r_prev_done;
  int          r_cnt;
  int          r_lat;
  logic [1:0]  p_op;
  logic [31:0] p_addr;
  logic [31:0] p_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // memory controller with protocol checks
  initial begin
    bus.mem_opdone = 1'b0;
    bus.data_i = '0;
    r_active = 0;
    r_prev_done = 0;
    p_op = '0;
    p_addr = '0;
    p_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        bus.mem_opdone = 1'b0;
        r_active = 0;
        r_prev_done = 0;
        p_op = '0;
        continue;
      end
      if (r_prev_done) begin
        chk("release", {30'd0, bus.mem_operation}, 32'd0);
      end else if (p_op != 2'b00) begin
        chk("hold_op", {30'd0, bus.mem_operation}, {30'd0, p_op});
        chk("hold_addr", bus.addr_o, p_addr);
        chk("hold_data", bus.data_o, p_data);
      end
      bus.mem_opdone = 1'b0;
      r_prev_done = 0;
      p_op = bus.mem_operation;
      p_addr = bus.addr_o;
      p_data = bus.data_o;
      if (bus.mem_operation != 2'b00) begin
        chk("addr_hi", bus.addr_o >> 8, 32'd0);
        if (!r_active) begin
          r_active = 1;
          r_cnt = 0;
          r_lat = (force_lat >= 0) ? force_lat
                : int'($urandom_range(0, 3));
        end
        if (r_cnt >= r_lat) begin
          log_q.push_back('{bus.mem_operation, bus.addr_o, bus.data_o});
          if (bus.mem_operation == 2'b11)
            sram[bus.addr_o[7:0]] = bus.data_o;
          else
            bus.data_i = sram[bus.addr_o[7:0]];
          bus.mem_opdone = 1'b1;
          r_prev_done = 1;
          r_active = 0;
          last_cyc = cyc;
        end else begin
          r_cnt++;
        end
      end
    end
  end

  task automatic load_sram(input logic [31:0] r, input logic [31:0] c);
    sram[IN_B] = r;
    sram[IN_B + 1] = c;
    for (int n = 0; n < 126; n++) sram[IN_B + 2 + n] = vals[n];
    for (int n = 128; n < 256; n++) sram[n] = '0;
  endtask

  task automatic load_44();
    int m44 [16] = '{1, -2, 3, 4, 5, 6, -7, 8,
                     -1, -2, -3, -4, -5, -6, -7, -8};
    for (int n = 0; n < 126; n++) vals[n] = '0;
    for (int n = 0; n < 16; n++) vals[n] = m44[n];
  endtask

  task automatic run_job(input string tag,
                         input logic [31:0] r,
                         input logic [31:0] c);
    bit bad;
    int ri, ci, hr, hc, a, nmin;
    logic signed [31:0] m, v;
    load_sram(r, c);
    bad = (r < 2) || (c < 2) || (r[31:16] != 0) || (c[31:16] != 0);
    exp_q.delete();
    log_q.delete();
    exp_q.push_back('{2'b01, IN_B, 0});
    exp_q.push_back('{2'b01, IN_B + 1, 0});
    if (!bad) begin
      ri = int'(r);
      ci = int'(c);
      hr = ri / 2;
      hc = ci / 2;
      for (int i = 0; i < hr; i++)
        for (int j = 0; j < hc; j++) begin
          m = 0;
          for (int q = 0; q < 4; q++) begin
            a = IN_B + 2 + (2 * i + q / 2) * ci + 2 * j + q % 2;
            exp_q.push_back('{2'b01, a, 0});
            v = sram[a];
            if (q == 0 || v > m) m = v;
          end
          exp_q.push_back('{2'b11, OUT_B + 2 + i * hc + j,
                            (m < 0) ? 32'd0 : m});
        end
      exp_q.push_back('{2'b11, OUT_B, hr});
      exp_q.push_back('{2'b11, OUT_B + 1, hc});
    end
    enable = 1'b1;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "/done"}, {31'd0, done}, 32'd1);
    chk({tag, "/lat"}, cyc - last_cyc, bad ? 32'd2 : 32'd1);
    chk({tag, "/err"}, {31'd0, error}, {31'd0, bad});
    chk({tag, "/ntx"}, log_q.size(), exp_q.size());
    nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int k = 0; k < nmin; k++) begin
      chk({tag, "/op"}, {30'd0, log_q[k].op}, {30'd0, exp_q[k].op});
      chk({tag, "/addr"}, log_q[k].addr, exp_q[k].addr);
      if (exp_q[k].op == 2'b11)
        chk({tag, "/wdata"}, log_q[k].data, exp_q[k].data);
    end
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "/done_fall"}, {31'd0, done}, 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "/done"}, {31'd0, done}, 32'd0);
    chk({tag, "/error"}, {31'd0, error}, 32'd0);
    chk({tag, "/addr"}, bus.addr_o, 32'd0);
    chk({tag, "/data"}, bus.data_o, 32'd0);
    chk({tag, "/op"}, {30'd0, bus.mem_operation}, 32'd0);
  endtask

  initial begin
    bit done_seen;
    int pos;
    logic [31:0] r, c;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    load_44();
    run_job("t4x4", 4, 4);
    chk("t4x4/ntx24", log_q.size(), 32'd24);
    chk("t4x4/hr", sram[128], 32'd2);
    chk("t4x4/hc", sram[129], 32'd2);
    chk("t4x4/e0", sram[130], 32'd6);
    chk("t4x4/e1", sram[131], 32'd8);
    chk("t4x4/e2", sram[132], 32'd0);
    chk("t4x4/e3", sram[133], 32'd0);

    for (int n = 0; n < 126; n++) vals[n] = n;
    run_job("t3x5", 3, 5);
    chk("t3x5/hr", sram[128], 32'd1);
    chk("t3x5/hc", sram[129], 32'd2);
    chk("t3x5/e0", sram[130], 32'd6);
    chk("t3x5/e1", sram[131], 32'd8);

    run_job("t1x8", 1, 8);
    chk("t1x8/ntx", log_q.size(), 32'd2);

    for (int n = 0; n < 4; n++) vals[n] = 32'h8000_0000;
    run_job("tmin", 2, 2);
    chk("tmin/e0", sram[130], 32'd0);

    pos = $urandom_range(0, 3);
    for (int n = 0; n < 4; n++)
      vals[n] = (n == pos) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
    run_job("tmax", 2, 2);
    chk("tmax/e0", sram[130], 32'h7FFF_FFFF);

    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < 126; n++)
        vals[n] = $urandom_range(0, 1) ? $urandom
                : $urandom_range(0, 20) - 10;
      r = $urandom_range(0, 10);
      c = $urandom_range(0, 11);
      if (t == 5) c = 32'h0001_0004;
      if (t == 6) r = 32'h0002_0003;
      run_job("rand", r, c);
    end

    // enable dropped while the first read is outstanding
    load_44();
    load_sram(4, 4);
    log_q.delete();
    force_lat = 3;
    enable = 1'b1;
    for (int t = 0; t < 20 && bus.mem_operation == 2'b00; t++) begin
      @(posedge clk);
      #1;
    end
    chk("abort/issue", {30'd0, bus.mem_operation}, 32'd1);
    enable = 1'b0;
    done_seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      if (done) done_seen = 1;
    end
    chk("abort/ntx", log_q.size(), 32'd1);
    chk("abort/done", {31'd0, done_seen}, 32'd0);
    chk("abort/op", {30'd0, bus.mem_operation}, 32'd0);
    force_lat = -1;

    // asynchronous reset in the middle of a window
    load_sram(4, 4);
    log_q.delete();
    enable = 1'b1;
    for (int t = 0; t < 200 &&
         !(log_q.size() >= 3 && bus.mem_operation == 2'b01); t++) begin
      @(posedge clk);
      #1;
    end
    chk("rst/inwin", {30'd0, bus.mem_operation}, 32'd1);
    #3 reset_n = 1'b0;
    #1 chk_outputs_zero("rst/async");
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_job("rerun", 4, 4);
    chk("rerun/e0", sram[130], 32'd6);
    chk("rerun/e1", sram[131], 32'd8);
    chk("rerun/hr", sram[128], 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
